ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Parametrised shared-RAM arbiter for the Y86 core, replacing the fixed two-source IRAM/DataRAM OR-merge. Arbitrates NUM_PORTS requesters (port 0 = instruction fetch, port 1 = data memory, further ports for DMA/debug) onto one RAM port. Each grant runs a registered read or write transaction that completes on a RAM ready handshake or a wait-state timeout. Grant selection is fixed-priority, or round-robin when configured.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 64, data width
- WAIT_MAX, 15, max cycles in BUSY before timeout (1..255)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- req  in  NUM_PORTS  per-port request, held until ack
- we  in  NUM_PORTS  per-port write (1) / read (0)
- addr  in  NUM_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_PORTS*DATA_W  per-port write data, same packing
- gnt  out  NUM_PORTS  one-hot, current owner during BUSY
- ack  out  NUM_PORTS  one-cycle completion pulse to owner
- err  out  1  one-cycle timeout pulse, coincident with ack
- rdata  out  DATA_W  read data, valid with ack, held until next ack
- ram_use  out  1  RAM transaction active
- ram_write  out  1  write strobe
- ram_read  out  1  read strobe
- ram_addr  out  ADDR_W  latched address
- ram_wdata  out  DATA_W  latched write data
- ram_rdata  in  DATA_W  RAM read data
- ram_ready  in  1  RAM completes current transaction

## Operation
- FSM: IDLE, BUSY, DONE.
- IDLE: if any req bit set, choose winner, latch its we/addr/wdata, set gnt one-hot, load wait counter to 0, go BUSY. Else stay.
- BUSY: ram_use=1, ram_write=latched we, ram_read=~latched we, ram_addr/ram_wdata = latched values (stable entire BUSY). Counter increments each cycle.
  - ram_ready=1: capture ram_rdata into rdata (reads only; writes leave rdata unchanged), go DONE.
  - ram_ready=0 and counter==WAIT_MAX-1: go DONE with err flag set; rdata unchanged.
  - ram_ready and timeout same cycle: ready wins, no err.
- DONE: ack[owner]=1 for this cycle, err=flag; gnt cleared, ram strobes low; go IDLE. Requester may deassert req in the DONE cycle; if still high in IDLE it is re-arbitrated as a new request.
- Requester dropping req during BUSY does not abort; transaction completes and ack still pulses.
- Changes to a granted port's addr/wdata/we during BUSY are ignored (latched).
- Fixed priority (default): lowest index wins.
- All state and outputs registered; ram_* outputs derive from state/latch registers only (no comb path from req).

## Timing
- Reset values: state=IDLE, gnt=0, ack=0, err=0, rdata=0, ram_use=0, ram_write=0, ram_read=0, ram_addr=0, ram_wdata=0, wait counter=0, rr pointer=0.
- Reset mid-transaction: immediate return to reset values; no ack issued for the aborted transaction.
- req sampled at edge k → BUSY (strobes high) from k+1. ram_ready sampled high at edge m → ack/rdata visible from m+1 for one cycle.
- Minimum transaction: 3 cycles (IDLE, BUSY with ready, DONE); back-to-back throughput one transaction per 3 cycles.
- Timeout: ack+err in cycle after WAIT_MAX BUSY cycles.

## Configuration
- RAM_ARB_RR_EN defined: round-robin. Pointer p (log2 NUM_PORTS bits); winner is first req bit at index ≥ p, wrapping modulo NUM_PORTS. On grant to port w, p ← (w+1) mod NUM_PORTS. Pointer updates on grant, not on completion.
- Undefined: fixed priority, port 0 highest; no pointer register.

## Test plan
- Single read, NUM_PORTS=2: req=01, we=0, addr0=0x100, ram_ready asserted 2nd BUSY cycle with ram_rdata=0xDEAD → ram_read high 2 cycles, ram_addr=0x100, ack=01 one cycle later, rdata=0xDEAD, err=0.
- Write: port 1 we=1, addr1=0x40, wdata1=0x1234, ready first BUSY cycle → ram_write=1, ram_wdata=0x1234, ack=10, rdata unchanged.
- Contention req=11 held, ready immediate: fixed → port 0 acked every transaction; RAM_ARB_RR_EN → ack alternates 01,10,01.
- Timeout WAIT_MAX=4, ram_ready never: ack and err pulse together after 4 BUSY cycles, ram strobes drop, FSM IDLE.
- Reset asserted in BUSY cycle 2 → all outputs 0 asynchronously, no ack after release; new req accepted normally.
- Addr/req change during BUSY: addr0 changes 0x100→0x200, req drops → ram_addr stays 0x100, ack still pulses.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester-side and RAM-side signals of the shared-RAM arbiter.
interface ram_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64
);
  logic [NUM_PORTS-1:0]        req, we, gnt, ack;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*DATA_W-1:0] wdata;
  logic                        err;
  logic [DATA_W-1:0]           rdata, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0]           ram_addr;
  logic                        ram_use, ram_write, ram_read, ram_ready;
  modport slave (
    input  req, we, addr, wdata, ram_rdata, ram_ready,
    output gnt, ack, err, rdata, ram_use, ram_write, ram_read, ram_addr, ram_wdata
  );
  modport master (
    output req, we, addr, wdata, ram_rdata, ram_ready,
    input  gnt, ack, err, rdata, ram_use, ram_write, ram_read, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: NUM_PORTS requesters onto one RAM port with wait-state timeout.
// Fixed priority (port 0 highest) by default; define RAM_ARB_RR_EN for round-robin.
module ram_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int WAIT_MAX  = 15
) (
  input logic         clk,
  input logic         rst,
  ram_arbiter_if.slave bus
);
  localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                state_q, state_d;
  logic [NUM_PORTS-1:0]  owner_q, owner_d;
  logic                  we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [PW-1:0]         ptr_q;
  int                    win;
`ifdef RAM_ARB_RR_EN
  logic [PW-1:0] ptr_d;
  // pointer advances past the winner at grant time, not at completion
  assign ptr_d = (state_q == IDLE && |bus.req) ? PW'((win + 1) % NUM_PORTS) : ptr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  assign ptr_q = '0;
`endif
  // scan downward so the first requester at or after the pointer wins
  always_comb begin
    win = 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (bus.req[(int'(ptr_q) + i) % NUM_PORTS]) win = (int'(ptr_q) + i) % NUM_PORTS;
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (|bus.req) begin
        state_d = BUSY;
        owner_d = NUM_PORTS'(1) << win;
        we_d    = bus.we[win];
        addr_d  = bus.addr[win*ADDR_W +: ADDR_W];
        wdata_d = bus.wdata[win*DATA_W +: DATA_W];
        err_d   = 1'b0;
        cnt_d   = '0;
      end
      BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.ram_ready) begin
          state_d = DONE;
          rdata_d = we_q ? rdata_q : bus.ram_rdata;
        end else if (cnt_q == 8'(WAIT_MAX - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.gnt       = state_q == BUSY ? owner_q : '0;
  assign bus.ack       = state_q == DONE ? owner_q : '0;
  assign bus.err       = state_q == DONE && err_q;
  assign bus.rdata     = rdata_q;
  assign bus.ram_use   = state_q == BUSY;
  assign bus.ram_write = state_q == BUSY && we_q;
  assign bus.ram_read  = state_q == BUSY && !we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_ram_arbiter;
  localparam int NP = 3, AW = 16, DW = 32, WM = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  ram_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus();
  ram_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int vecs = 0, errs = 0;
  bit act, done, m_we, m_err;
  int own, cyc, ptr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    act = 0; done = 0; m_we = 0; m_err = 0; own = 0; cyc = 0; ptr = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask
  // one transaction at a time: grant, count RAM wait cycles, then a completion cycle
  task automatic model_edge();
    if (done) done = 0;
    else if (act) begin
      cyc++;
      if (bus.ram_ready) begin
        if (!m_we) m_rdata = bus.ram_rdata;
        act = 0; done = 1; m_err = 0;
      end else if (cyc == WM) begin
        act = 0; done = 1; m_err = 1;
      end
    end else if (bus.req != 0) begin
      for (int k = NP - 1; k >= 0; k--)
        if (bus.req[(ptr + k) % NP]) own = (ptr + k) % NP;
`ifdef RAM_ARB_RR_EN
      ptr = (own + 1) % NP;
`endif
      m_we = bus.we[own];
      m_addr = bus.addr[own*AW +: AW];
      m_wdata = bus.wdata[own*DW +: DW];
      act = 1; cyc = 0;
    end
  endtask
  task automatic check_all();
    logic [NP-1:0] oh;
    oh = '0;
    oh[own] = 1'b1;
    check("gnt", 64'(bus.gnt), act ? 64'(oh) : 64'd0);
    check("ack", 64'(bus.ack), done ? 64'(oh) : 64'd0);
    check("err", 64'(bus.err), 64'(done && m_err));
    check("rdata", 64'(bus.rdata), 64'(m_rdata));
    check("ram_use", 64'(bus.ram_use), 64'(act));
    check("ram_write", 64'(bus.ram_write), 64'(act && m_we));
    check("ram_read", 64'(bus.ram_read), 64'(act && !m_we));
    check("ram_addr", 64'(bus.ram_addr), 64'(m_addr));
    check("ram_wdata", 64'(bus.ram_wdata), 64'(m_wdata));
  endtask
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    check_all();
  endtask
  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we[p] = w;
    bus.addr[p*AW +: AW] = a;
    bus.wdata[p*DW +: DW] = d;
  endtask
  initial begin
    int n0, n1;
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    bus.ram_rdata = '0; bus.ram_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    // single read, ready on the second BUSY cycle
    set_port(0, 1'b0, 16'h0100, 32'h0);
    bus.req = 3'b001;
    cycle();
    check("rd_strobe1", 64'(bus.ram_read), 64'd1);
    check("rd_addr", 64'(bus.ram_addr), 64'h100);
    cycle();
    check("rd_strobe2", 64'(bus.ram_read), 64'd1);
    bus.ram_ready = 1'b1; bus.ram_rdata = 32'hDEAD;
    cycle();
    check("rd_ack", 64'(bus.ack), 64'b001);
    check("rd_rdata", 64'(bus.rdata), 64'hDEAD);
    check("rd_err", 64'(bus.err), 64'd0);
    bus.req = '0; bus.ram_ready = 1'b0;
    cycle();
    // write on port 1, ready on the first BUSY cycle
    set_port(1, 1'b1, 16'h0040, 32'h1234);
    bus.req = 3'b010; bus.ram_ready = 1'b1; bus.ram_rdata = 32'hBEEF;
    cycle();
    check("wr_strobe", 64'(bus.ram_write), 64'd1);
    check("wr_wdata", 64'(bus.ram_wdata), 64'h1234);
    cycle();
    check("wr_ack", 64'(bus.ack), 64'b010);
    check("wr_rdata_kept", 64'(bus.rdata), 64'hDEAD);
    bus.req = '0;
    cycle();
    // contention between ports 0 and 1, three back-to-back transactions
    set_port(1, 1'b0, 16'h0041, 32'h0);
    bus.req = 3'b011;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 9; i++) begin
      cycle();
      if (bus.ack[0]) n0++;
      if (bus.ack[1]) n1++;
    end
`ifdef RAM_ARB_RR_EN
    check("cont_p0", 64'(n0), 64'd2);
    check("cont_p1", 64'(n1), 64'd1);
`else
    check("cont_p0", 64'(n0), 64'd3);
    check("cont_p1", 64'(n1), 64'd0);
`endif
    bus.req = '0; bus.ram_ready = 1'b0;
    cycle();
    // timeout on port 2: ready never comes
    set_port(2, 1'b0, 16'h0300, 32'h0);
    bus.req = 3'b100;
    for (int i = 0; i < WM + 1; i++) cycle();
    check("to_ack", 64'(bus.ack), 64'b100);
    check("to_err", 64'(bus.err), 64'd1);
    bus.req = '0;
    cycle();
    check("to_idle", 64'(bus.ram_use), 64'd0);
    // reset in the second BUSY cycle
    bus.req = 3'b001;
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    check("rst_gnt", 64'(bus.gnt), 64'd0);
    check("rst_use", 64'(bus.ram_use), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    model_reset();
    bus.req = '0;
    @(negedge clk);
    check_all();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    bus.req = 3'b001; bus.ram_ready = 1'b1;
    cycle();
    cycle();
    check("post_rst_ack", 64'(bus.ack), 64'b001);
    bus.req = '0; bus.ram_ready = 1'b0;
    cycle();
    // addr and req change during BUSY are ignored
    set_port(0, 1'b0, 16'h0100, 32'h0);
    bus.req = 3'b001;
    cycle();
    set_port(0, 1'b0, 16'h0200, 32'h0);
    bus.req = '0;
    cycle();
    check("latch_addr", 64'(bus.ram_addr), 64'h100);
    bus.ram_ready = 1'b1;
    cycle();
    check("drop_ack", 64'(bus.ack), 64'b001);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.req = NP'($urandom_range(0, (1 << NP) - 1));
      for (int p = 0; p < NP; p++) set_port(p, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      bus.ram_ready = 1'($urandom_range(0, 1));
      bus.ram_rdata = DW'($urandom);
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
